// File: rtl/sbit_emu_pkg.sv
// Shared encodings, widths and helpers for the VFAT3 S-bit frame emulator.
package sbit_emu_pkg;

  localparam int unsigned SETTLE_CYCLES = 4;
  localparam int unsigned SETTLE_CNT_W  = $clog2(SETTLE_CYCLES);
  localparam int unsigned PHASE_W       = 3;
  localparam int unsigned GLITCH_W      = 12;
  localparam int unsigned FCNT_W        = 16;
  localparam int unsigned MODE_W        = 2;
  localparam int unsigned SOF_W         = 8;

  typedef enum logic [MODE_W-1:0] {
    MODE_USER = 2'd0,
    MODE_WALK = 2'd1,
    MODE_CNT  = 2'd2,
    MODE_ZERO = 2'd3
  } emu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } emu_state_e;

  // SoF bit k pairs with receiver slip k+1, so phase p marks bit (p-1) mod 8.
  function automatic logic [SOF_W-1:0] sof_onehot(input logic [PHASE_W-1:0] p);
    return SOF_W'(1) << PHASE_W'(p - PHASE_W'(1));
  endfunction

endpackage

// File: rtl/lane_rotator.sv
// One lane: registered barrel shift of {cur, prev} by the emulated frame phase.
module lane_rotator
  import sbit_emu_pkg::*;
#(
  parameter int unsigned FRAME_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [PHASE_W-1:0]    phase_i,
  input  logic [FRAME_SIZE-1:0] cur_i,
  input  logic [FRAME_SIZE-1:0] prev_i,
  output logic [FRAME_SIZE-1:0] out_o
);

  logic [2*FRAME_SIZE-1:0] cat;
  logic [FRAME_SIZE-1:0]   out_d;
  logic [FRAME_SIZE-1:0]   out_q;

  always_comb begin
    cat   = {cur_i, prev_i};
    out_d = '0;
    if (load_i) begin
      out_d = FRAME_SIZE'(cat >> (FRAME_SIZE - 32'(phase_i)));
    end
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/sbit_frame_emulator.sv
// Transmit-side VFAT3 S-bit link emulator: phase-rotated frames, one-hot SoF,
// settle handling on phase changes and periodic SoF glitch injection.
module sbit_frame_emulator
  import sbit_emu_pkg::*;
#(
  parameter int unsigned MXSBITS    = 64,
  parameter int unsigned FRAME_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [MODE_W-1:0]     mode_i,
  input  logic [MXSBITS-1:0]    sbits_i,
  input  logic [PHASE_W-1:0]    phase_i,
  input  logic [GLITCH_W-1:0]   glitch_period_i,
  output logic [MXSBITS-1:0]    sbits_o,
  output logic [FRAME_SIZE-1:0] start_of_frame_o,
  output logic                  glitch_o,
  output logic                  settling_o,
  output logic [FCNT_W-1:0]     frame_count_o
);

  localparam int unsigned NUM_LANES = MXSBITS / FRAME_SIZE;
  localparam int unsigned WALK_W    = $clog2(MXSBITS);

  emu_state_e state_q, state_d;

  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic [WALK_W-1:0]       walk_q, walk_d;
  logic [MXSBITS-1:0]      cur_q, cur_d;
  logic [MXSBITS-1:0]      prev_q, prev_d;
  logic [FRAME_SIZE-1:0]   sof_q, sof_d;
  logic                    glitch_q, glitch_d;
  logic                    settling_q, settling_d;
  logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
  logic [GLITCH_W-1:0]     gcnt_q, gcnt_d;

  logic                    emit;
  logic                    enter_run;
  logic                    in_settle;
  logic                    phase_chg;
  logic                    run_now;
  logic                    run_next;
  logic                    fire;
  logic [GLITCH_W-1:0]     gcnt_inc;
  logic [WALK_W-1:0]       widx;
  logic [FRAME_SIZE-1:0]   cnt_byte;

  always_ff @(posedge clock) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable_i) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_cnt_q == SETTLE_CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_RUN;
      ST_RUN:    if (phase_i != phase_q) state_d = ST_SETTLE;
      default:   state_d = ST_IDLE;
    endcase
    if (!enable_i) state_d = ST_IDLE;
  end

  // A RUN cycle emits the frame captured one cycle earlier, unless enable drops.
  always_comb begin
    emit      = 1'b0;
    enter_run = 1'b0;
    in_settle = 1'b0;
    phase_chg = 1'b0;
    run_now   = (state_q == ST_RUN);
    run_next  = (state_d == ST_RUN);
    case (state_q)
      ST_SETTLE: begin
        in_settle = enable_i;
        enter_run = run_next;
      end
      ST_RUN: begin
        emit      = enable_i;
        phase_chg = (state_d == ST_SETTLE);
      end
      default: ;
    endcase
  end

  // Stage 1 source select; the count byte anticipates the frames emitted before it leaves.
  always_comb begin
    widx     = enter_run ? '0 : walk_q;
    walk_d   = run_next ? WALK_W'(widx + WALK_W'(1)) : walk_q;
    cnt_byte = FRAME_SIZE'(fcnt_q) + FRAME_SIZE'(run_now) + FRAME_SIZE'(run_next);
    case (mode_i)
      MODE_USER: cur_d = sbits_i;
      MODE_WALK: cur_d = MXSBITS'(1) << widx;
      MODE_CNT:  cur_d = {NUM_LANES{cnt_byte}};
      default:   cur_d = '0;
    endcase
    prev_d       = enter_run ? '0 : cur_q;
    settle_cnt_d = (state_q == ST_SETTLE) ? SETTLE_CNT_W'(settle_cnt_q + SETTLE_CNT_W'(1)) : '0;
    phase_d      = enter_run ? phase_i : phase_q;
  end

  // Glitch counter, SoF encode and frame counter for the stage-2 output registers.
  always_comb begin
    gcnt_inc = GLITCH_W'(gcnt_q + GLITCH_W'(1));
    fire     = emit && !phase_chg && (glitch_period_i != '0) && (gcnt_inc == glitch_period_i);
    gcnt_d   = gcnt_q;
    if (!enable_i || (glitch_period_i == '0)) begin
      gcnt_d = '0;
    end else if (emit) begin
      gcnt_d = (phase_chg || fire) ? '0 : gcnt_inc;
    end
    sof_d      = (emit && !fire) ? FRAME_SIZE'(sof_onehot(phase_q)) : '0;
    glitch_d   = fire;
    settling_d = in_settle;
    fcnt_d     = fcnt_q;
    if (!enable_i) begin
      fcnt_d = '0;
    end else if (emit) begin
      fcnt_d = FCNT_W'(fcnt_q + FCNT_W'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset_i) begin
      settle_cnt_q <= '0;
      phase_q      <= '0;
      walk_q       <= '0;
      cur_q        <= '0;
      prev_q       <= '0;
      sof_q        <= '0;
      glitch_q     <= 1'b0;
      settling_q   <= 1'b0;
      fcnt_q       <= '0;
      gcnt_q       <= '0;
    end else begin
      settle_cnt_q <= settle_cnt_d;
      phase_q      <= phase_d;
      walk_q       <= walk_d;
      cur_q        <= cur_d;
      prev_q       <= prev_d;
      sof_q        <= sof_d;
      glitch_q     <= glitch_d;
      settling_q   <= settling_d;
      fcnt_q       <= fcnt_d;
      gcnt_q       <= gcnt_d;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lane_rotator #(
      .FRAME_SIZE(FRAME_SIZE)
    ) u_rot (
      .clock  (clock),
      .reset_i(reset_i),
      .load_i (emit),
      .phase_i(phase_q),
      .cur_i  (cur_q[l*FRAME_SIZE +: FRAME_SIZE]),
      .prev_i (prev_q[l*FRAME_SIZE +: FRAME_SIZE]),
      .out_o  (sbits_o[l*FRAME_SIZE +: FRAME_SIZE])
    );
  end

  assign start_of_frame_o = sof_q;
  assign glitch_o         = glitch_q;
  assign settling_o       = settling_q;
  assign frame_count_o    = fcnt_q;

endmodule

// File: tb/tb_sbit_frame_emulator.sv
// Directed-plus-random bench for sbit_frame_emulator with a frame-level reference model.
module tb_sbit_frame_emulator;
  import sbit_emu_pkg::*;

  logic        clock = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [1:0]  mode_i;
  logic [63:0] sbits_i;
  logic [2:0]  phase_i;
  logic [11:0] glitch_period_i;
  logic [63:0] sbits_o;
  logic [7:0]  start_of_frame_o;
  logic        glitch_o;
  logic        settling_o;
  logic [15:0] frame_count_o;

  sbit_frame_emulator dut (
    .clock           (clock),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .mode_i          (mode_i),
    .sbits_i         (sbits_i),
    .phase_i         (phase_i),
    .glitch_period_i (glitch_period_i),
    .sbits_o         (sbits_o),
    .start_of_frame_o(start_of_frame_o),
    .glitch_o        (glitch_o),
    .settling_o      (settling_o),
    .frame_count_o   (frame_count_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept per RUN segment in frame terms.
  int          m_p;
  logic [15:0] m_fc;
  int          m_gs;
  int          seg_k;
  logic [15:0] seg_fc0;
  logic [63:0] m_prev;
  logic        pend_v;
  logic [63:0] pend_data;
  int          glitches_seen;
  int          wraps_seen;
  logic        use_fixed;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Output bit i of a lane comes from cur[i-p] when i >= p, otherwise from the tail of prev.
  function automatic logic [63:0] rot64(input logic [63:0] cur, input logic [63:0] prev, input int p);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 8; l++)
      for (int i = 0; i < 8; i++)
        r[8*l+i] = (i >= p) ? cur[8*l+i-p] : prev[8*l+8-p+i];
    return r;
  endfunction

  function automatic logic [7:0] sof_of(input int p);
    logic [7:0] one;
    one = 8'h01;
    return one << ((p + 7) % 8);
  endfunction

  task automatic chk_quiet(input string tag, input logic exp_settling, input logic [15:0] exp_fc);
    chk({tag, "_data"}, sbits_o, 64'h0);
    chk({tag, "_sof"}, 64'(start_of_frame_o), 64'h0);
    chk({tag, "_glitch"}, 64'(glitch_o), 64'h0);
    chk({tag, "_settling"}, 64'(settling_o), 64'(exp_settling));
    chk({tag, "_fcount"}, 64'(frame_count_o), 64'(exp_fc));
  endtask

  task automatic emit_check(input bit pchg);
    logic       exp_g;
    logic [7:0] exp_sof;
    m_fc  = m_fc + 16'd1;
    exp_g = 1'b0;
    if (pchg || glitch_period_i == 12'd0) m_gs = 0;
    else if (m_gs + 1 == int'(glitch_period_i)) begin
      exp_g = 1'b1;
      m_gs  = 0;
    end else m_gs++;
    exp_sof = exp_g ? 8'h00 : sof_of(m_p);
    chk("frame_data", sbits_o, pend_data);
    chk("frame_sof", 64'(start_of_frame_o), 64'(exp_sof));
    chk("frame_glitch", 64'(glitch_o), 64'(exp_g));
    chk("frame_count", 64'(frame_count_o), 64'(m_fc));
    chk("frame_settling", 64'(settling_o), 64'h0);
    if (glitch_o) glitches_seen++;
    if (frame_count_o == 16'd0) wraps_seen++;
    pend_v = 1'b0;
  endtask

  task automatic new_segment(input int p);
    m_p     = p;
    seg_k   = 0;
    m_prev  = '0;
    seg_fc0 = m_fc;
    pend_v  = 1'b0;
  endtask

  task automatic settle_ticks();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("settle", 1'b1, m_fc);
    end
  endtask

  task automatic run_frames(input int n);
    logic [63:0] cur;
    logic [63:0] rnd;
    for (int f = 0; f < n; f++) begin
      rnd = {$urandom, $urandom};
      if (use_fixed) begin
        rnd       = 64'h0123_4567_89AB_CDEF;
        use_fixed = 1'b0;
      end
      sbits_i = rnd;
      case (mode_i)
        2'd0:    cur = rnd;
        2'd1:    cur = 64'd1 << (seg_k % 64);
        2'd2:    cur = {8{8'(int'(seg_fc0) + seg_k + 1)}};
        default: cur = '0;
      endcase
      tick();
      if (pend_v) emit_check(1'b0);
      else chk_quiet("settle_last", 1'b1, m_fc);
      pend_data = rot64(cur, m_prev, m_p);
      m_prev    = cur;
      pend_v    = 1'b1;
      seg_k++;
    end
  endtask

  task automatic start(input int p);
    phase_i  = 3'(p);
    enable_i = 1'b1;
    m_fc     = '0;
    m_gs     = 0;
    tick();
    chk_quiet("enable_edge", 1'b0, 16'h0);
    settle_ticks();
    new_segment(p);
  endtask

  task automatic change_phase(input int p);
    phase_i = 3'(p);
    tick();
    emit_check(1'b1);
    settle_ticks();
    new_segment(p);
  endtask

  initial begin
    reset_i         = 1'b1;
    enable_i        = 1'b0;
    mode_i          = 2'd0;
    sbits_i         = '0;
    phase_i         = 3'd0;
    glitch_period_i = 12'd0;
    use_fixed       = 1'b0;
    glitches_seen   = 0;
    wraps_seen      = 0;
    m_fc            = '0;
    m_gs            = 0;
    pend_v          = 1'b0;
    tick();
    tick();
    chk_quiet("reset", 1'b0, 16'h0);
    chk("reset_phase_q", 64'(dut.phase_q), 64'h0);
    chk("reset_state", 64'(dut.state_q), 64'(ST_IDLE));
    reset_i = 1'b0;
    tick();
    chk_quiet("idle", 1'b0, 16'h0);

    // User data at phase 0: fixed word first, then random words.
    use_fixed = 1'b1;
    start(0);
    run_frames(12);

    // Walking one at phase 3, across the 63 -> 0 wrap.
    mode_i = 2'd1;
    change_phase(3);
    run_frames(128);

    // Zero mode, then user data at phase 2 with glitches every 10 frames.
    mode_i = 2'd3;
    run_frames(4);
    mode_i = 2'd0;
    change_phase(2);
    run_frames(3);
    glitch_period_i = 12'd10;
    glitches_seen   = 0;
    run_frames(50);
    chk("glitch_count_50", 64'(glitches_seen), 64'd5);

    // Line a glitch up with a phase change: the change must win.
    for (int i = 0; i < 20 && m_gs != 9; i++) run_frames(1);
    change_phase(5);
    run_frames(25);

    // Frame-counter pattern at phase 0 across the 16-bit wrap.
    glitch_period_i = 12'd0;
    mode_i          = 2'd2;
    change_phase(0);
    wraps_seen = 0;
    run_frames(65536);
    chk("fcount_wraps", 64'(wraps_seen), 64'd1);

    // Reset mid-RUN.
    reset_i  = 1'b1;
    enable_i = 1'b0;
    tick();
    chk_quiet("reset_run", 1'b0, 16'h0);
    chk("reset_run_phase_q", 64'(dut.phase_q), 64'h0);
    chk("reset_run_state", 64'(dut.state_q), 64'(ST_IDLE));
    reset_i = 1'b0;

    // Run at phase 6, drop enable mid-RUN, then again mid-SETTLE.
    mode_i = 2'd0;
    start(6);
    run_frames(5);
    enable_i = 1'b0;
    tick();
    chk_quiet("drop_run", 1'b0, 16'h0);
    m_fc    = '0;
    m_gs    = 0;
    pend_v  = 1'b0;
    phase_i  = 3'd1;
    enable_i = 1'b1;
    tick();
    chk_quiet("resettle_edge", 1'b0, 16'h0);
    tick();
    chk_quiet("resettle", 1'b1, 16'h0);
    enable_i = 1'b0;
    tick();
    chk_quiet("drop_settle", 1'b0, 16'h0);
    chk("drop_settle_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("drop_settle_phase_q", 64'(dut.phase_q), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sbit_frame_emulator.md
# sbit_frame_emulator

Transmit-side emulator of the VFAT3 S-bit trigger link. Each 40 MHz cycle it produces one 8-bit frame per lane for 8 lanes (64 S-bits) plus the 8-bit one-hot start-of-frame (SoF) word. The data is rotated by a programmable phase, and SoF glitches can be injected. It sits in the trigger test path ahead of the per-VFAT frame alignment logic, so alignment, bitslip and unstable-SoF detection can be exercised in loopback without front-end hardware.

## Interface
Parameters:
- MXSBITS, 64, total S-bits per VFAT (8 lanes × FRAME_SIZE)
- FRAME_SIZE, 8, bits per frame per lane; only 8 is supported

Ports:
- clock  in  1  40 MHz frame clock; the only clock
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  1  leave IDLE when high
- mode_i  in  2  data source: 0 = sbits_i, 1 = walking one, 2 = frame-counter pattern, 3 = zeros
- sbits_i  in  MXSBITS  user S-bits, sampled every cycle
- phase_i  in  3  frame phase p (0..7) to emulate
- glitch_period_i  in  12  frames between SoF glitches; 0 disables glitches
- sbits_o  out  MXSBITS  rotated frames, lane L = bits [8L+7:8L]
- start_of_frame_o  out  FRAME_SIZE  one-hot SoF, or 0 during glitch/settle/idle
- glitch_o  out  1  one-cycle pulse, coincident with a glitched SoF
- settling_o  out  1  high in SETTLE
- frame_count_o  out  16  frames emitted in RUN; wraps

## Operation
- FSM states: IDLE, SETTLE, RUN.
  - IDLE -> SETTLE when enable_i = 1.
  - SETTLE: lasts SETTLE_CYCLES = 4 cycles. sbits_o = 0, SoF = 0, settling_o = 1. On the last cycle, phase_q <= phase_i, then -> RUN.
  - RUN -> SETTLE when phase_i != phase_q. This check has priority over glitch injection.
  - Any state -> IDLE when enable_i = 0. IDLE outputs are all 0.
- Source word cur (registered stage 1):
  - mode 0: sbits_i
  - mode 1: a single 1 at index w. w advances by 1 per RUN frame, wraps 63 -> 0, and resets to 0 on entry to RUN.
  - mode 2: every lane = frame_count[7:0]
  - mode 3: 0
- prev holds the previous cur. prev is cleared on entry to RUN.
- Rotation, per lane: out = ({cur_lane, prev_lane} >> (8 − p))[7:0] with p = phase_q. p = 0 passes cur_lane unchanged.
- SoF in RUN: one-hot with bit (p − 1) mod 8 set. Receiver convention: SoF bit k ↔ slip (k + 1) mod 8, so a matched receiver recovers cur.
- Glitch: when glitch_period_i != 0, a frame-since-glitch counter counts RUN frames. When it reaches glitch_period_i, that cycle's SoF = 0, glitch_o = 1, and the counter clears. Data is unaffected. Writing 0 clears the counter and stops glitches.
- frame_count increments once per RUN cycle and wraps 0xFFFF -> 0. It holds in SETTLE and clears in IDLE.

## Timing
- Reset: all outputs 0, state IDLE, phase_q = 0, all counters 0.
- Latency: sbits_i -> sbits_o is 2 cycles at p = 0 (input register + output register). start_of_frame_o, glitch_o and frame_count_o are registered and aligned with the sbits_o they describe.
- A change to mode_i takes effect on the next stage-1 register; the output pipeline is not flushed.
- Simultaneous phase change and glitch: phase change wins. No glitch is emitted, and the glitch counter clears.
- enable_i drop mid-SETTLE: go to IDLE immediately. phase_q is not updated.
- reset_i has priority over all inputs in every state.

## Structure
- Package sbit_emu_pkg: mode encodings (MODE_USER, MODE_WALK, MODE_CNT, MODE_ZERO), state enum, SETTLE_CYCLES = 4.
- Sub-module lane_rotator, instantiated once per lane: registered {cur, prev}-to-out barrel shift selected by p.
- Top level holds the FSM, counters, source mux and SoF encode. Expected size is about 200 lines.

## Test plan
- Reset, enable = 1, mode 0, p = 0, sbits_i = 0x0123456789ABCDEF: settling_o high for 4 cycles, then sbits_o = input 2 cycles later, SoF = 0x80.
- p = 3, mode 1: SoF = 0x04. Lane 0 output = ({cur, prev} >> 5)[7:0], checked against a reference model over 128 frames including the 63 -> 0 wrap of the walking one.
- glitch_period = 10, run 50 frames: exactly 5 cycles with SoF = 0 and glitch_o = 1, spaced 10 frames apart. Data is unchanged on those cycles.
- phase_i changes 2 -> 5 in RUN: 4 settle cycles with zero outputs, then SoF = 0x10. A glitch due in the same cycle is suppressed.
- mode 2, run 65 536 frames: frame_count_o wraps to 0 and lane bytes track frame_count[7:0].
- reset_i asserted mid-RUN and enable_i dropped mid-SETTLE: next cycle all outputs are 0 and the state is IDLE. For the reset case phase_q = 0; for the enable-drop case phase_q is unchanged.
